// File: rtl/mu01_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mu01_pkg
// Shared definitions for the MU01 memory responder slice.
//   MU01_ADDR_W / MU01_DATA_W : default bus address and word widths
//   OP_*                      : MU01 opcode encodings (top nibble of a word)
//   resp_state_e              : responder FSM state encoding
// ---------------------------------------------------------------------------
package mu01_pkg;

    localparam int MU01_ADDR_W = 12;
    localparam int MU01_DATA_W = 16;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mu01_mem_responder_if.sv
// ---------------------------------------------------------------------------
// mu01_bus_if
// MU01 processor bus plus the program-loader port.
//   req/we/addr/wdata        : initiator request, held until ack
//   ack/rdata/err/busy       : responder completion and status
//   ld_en/ld_addr/ld_data    : loader write strobe, address and data
//   ld_rdy                   : loader write will be taken this cycle
// Modports: master = initiator + loader side, slave = responder side.
// ---------------------------------------------------------------------------
interface mu01_bus_if
    import mu01_pkg::*;
#(
    parameter int ADDR_W = MU01_ADDR_W,
    parameter int DATA_W = MU01_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_rdy;

    modport master (
        output req, we, addr, wdata, ld_en, ld_addr, ld_data,
        input  ack, rdata, err, busy, ld_rdy
    );

    modport slave (
        input  req, we, addr, wdata, ld_en, ld_addr, ld_data,
        output ack, rdata, err, busy, ld_rdy
    );
endinterface

// File: rtl/mu01_mem_responder_sram.sv
// ---------------------------------------------------------------------------
// mu01_sram
// Single-port 1RW storage array, DEPTH x DW, synchronous write and
// combinational read. No reset: contents survive responder resets.
//   clk_i   : write clock
//   we_i    : write enable
//   addr_i  : word address (shared by read and write)
//   wdata_i : write data
//   rdata_o : read data at addr_i
// ---------------------------------------------------------------------------
module mu01_sram #(
    parameter int AW    = 12,
    parameter int DW    = 16,
    parameter int DEPTH = 4096
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mu01_mem_responder.sv
// ---------------------------------------------------------------------------
// mu01_mem_responder
// Memory-side responder for the MU01 bus: owns the unified instruction/data
// store, services read and write requests with WAIT_STATES extra cycles,
// and accepts program-loader writes whenever it is idle.
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset (array contents are kept)
//   bus    : mu01_bus_if slave (request/ack bus and loader port)
// ---------------------------------------------------------------------------
module mu01_mem_responder
    import mu01_pkg::*;
#(
    parameter int ADDR_W      = MU01_ADDR_W,
    parameter int DATA_W      = MU01_DATA_W,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    mu01_bus_if.slave   bus
);

    localparam int SRAM_AW = $clog2(DEPTH);

    resp_state_e       state_q;
    logic [3:0]        wait_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_q;
    logic              err_q;
    logic              busy_q;
    logic [DATA_W-1:0] rdata_q;

    logic              is_idle;
    logic              accept;
    logic              go_resp;
    logic              bus_addr_ok;
    logic              ld_addr_ok;
    logic              addr_q_ok;
    logic              resp_ok;
    logic              resp_we;
    logic [ADDR_W-1:0] port_addr;
    logic              port_we;
    logic [DATA_W-1:0] port_wdata;
    logic [DATA_W-1:0] port_rdata;

    assign is_idle     = (state_q == ST_IDLE);
    // The loader has priority: a request seen together with ld_en waits an edge.
    assign accept      = is_idle && bus.req && !bus.ld_en;
    assign bus_addr_ok = int'(bus.addr) < DEPTH;
    assign ld_addr_ok  = int'(bus.ld_addr) < DEPTH;
    assign addr_q_ok   = int'(addr_q) < DEPTH;

    // With zero wait states the response is built straight from the live bus
    // values at the accept edge; otherwise from the latched copies.
    assign go_resp = (accept && (WAIT_STATES == 0)) ||
                     ((state_q == ST_WAIT) && (wait_cnt_q == 4'd0));
    assign resp_ok = is_idle ? bus_addr_ok : addr_q_ok;
    assign resp_we = is_idle ? bus.we : we_q;

    // Single storage port: loader (or the zero-wait read) while idle, the
    // latched transaction otherwise. Stores commit on the edge leaving RESP.
    always_comb begin
        port_addr  = addr_q;
        port_wdata = wdata_q;
        port_we    = 1'b0;
        if (is_idle) begin
            port_addr  = bus.ld_en ? bus.ld_addr : bus.addr;
            port_wdata = bus.ld_data;
            port_we    = bus.ld_en && ld_addr_ok;
        end else if (state_q == ST_RESP) begin
            port_we = we_q && addr_q_ok;
        end
    end

    mu01_sram #(
        .AW    (SRAM_AW),
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_sram (
        .clk_i   (clk_i),
        .we_i    (port_we),
        .addr_i  (port_addr[SRAM_AW-1:0]),
        .wdata_i (port_wdata),
        .rdata_o (port_rdata)
    );

    // Responder FSM with registered ack/err/busy/rdata. ack is high exactly
    // during RESP; rdata and err hold their values between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q     <= bus.addr;
                        we_q       <= bus.we;
                        wdata_q    <= bus.wdata;
                        busy_q     <= 1'b1;
                        wait_cnt_q <= 4'(WAIT_STATES - 1);
                        state_q    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (go_resp) begin
                ack_q <= 1'b1;
                err_q <= !resp_ok;
                if (!resp_ok) begin
                    rdata_q <= '0;
                end else if (!resp_we) begin
                    rdata_q <= port_rdata;
                end
            end
        end
    end

    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.rdata  = rdata_q;
    assign bus.ld_rdy = is_idle;

endmodule
